param_byte_memory: RTL
======================

Name: param_byte_memory

Overview:
- Parametrised successor to the 4-byte memory: DEPTH words of DATA_W bits, single port, synchronous write, registered read.
- Adds an out_valid qualifier, a hardware clear sequencer that zeroes every word after reset or on request, and a busy flag.
- Sits behind bus-facing control logic as a small scratch store; replaces the fixed 4x8 tri-state-output memory.

Parameters:
- DATA_W, 8, word width in bits (>=1).
- ADDR_W, 2, address width in bits (>=1).
- DEPTH, 4, number of words; 2 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  access request; sampled only when busy=0.
- wr  input  1  1=write, 0=read; meaningful only with en=1.
- adr  input  ADDR_W  word address.
- data  input  DATA_W  write data.
- clr  input  1  1-cycle pulse requesting a full zero-fill; sampled only in IDLE.
- out  output  DATA_W  read data; driven at all times, never tri-stated.
- out_valid  output  1  out holds fresh read data this cycle.
- busy  output  1  clear sequence in progress; accesses are ignored.

Behaviour:
- Reset (rst=1 at an edge), overriding everything:
  - out=0, out_valid=0, busy=1, clear counter cnt=0, state=CLEAR.
  - Memory contents are not touched by the reset edge itself; the CLEAR sequence zeroes them.
- FSM has two states, IDLE and CLEAR.
- CLEAR:
  - Each cycle writes 0 to mem[cnt], then increments cnt.
  - When cnt=DEPTH-1 is written, the next state is IDLE and busy falls the following cycle.
  - Duration is exactly DEPTH cycles; busy=1 throughout. en, wr, clr are ignored; out_valid=0; out holds its value.
- IDLE, transitions:
  - clr=1 -> CLEAR next cycle, cnt=0, busy=1 next cycle.
  - clr has priority over a same-cycle en; that access is dropped.
- IDLE, write (en=1, wr=1, clr=0):
  - mem[adr]<=data at the edge.
  - out_valid=0 next cycle; out unchanged.
- IDLE, read (en=1, wr=0, clr=0):
  - Next cycle out=mem[adr] and out_valid=1; latency 1 cycle.
  - out_valid is a single-cycle pulse per read; back-to-back reads give consecutive pulses.
  - out holds the last read value until the next read completes.
- Read-after-write to the same address on consecutive cycles returns the new data (write lands first).
- IDLE, en=0: out_valid=0; no state change.
- Out-of-range address (adr>=DEPTH, possible when DEPTH<2**ADDR_W):
  - Write is ignored.
  - Read returns out=0 with out_valid=1.
- Reset mid-CLEAR or mid-read:
  - Restarts CLEAR from cnt=0.
  - A pending out_valid is cancelled.
- Counter width is ADDR_W; it never exceeds DEPTH-1.

Optional Feature:
- Macro: PARAM_BYTE_MEMORY_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit (XOR of data), computed on write; CLEAR stores parity 0.
  - Extra output port par_err (1 bit) is registered with out.
  - par_err=1 in the out_valid cycle when the stored parity mismatches the stored data, otherwise 0.
  - Out-of-range reads give par_err=0; reset value 0.
- Undefined: no parity storage and no par_err port; behaviour otherwise identical.

Test Plan:
- Reset clear: rst high 1 cycle with DEPTH=4 -> busy=1 for exactly 4 cycles, then 0; reads of addresses 0..3 give out=0x00, out_valid=1 each, 1 cycle after each request.
- Write/read: write 0xA5@1, 0x3C@2, then read 1, read 2 back-to-back -> out=0xA5 then 0x3C, out_valid high 2 consecutive cycles.
- Access during busy: pulse clr, then write 0xFF@0 in the second busy cycle -> after busy falls, read 0 returns 0x00.
- Clear vs access: clr=1 with en=1, wr=1, data=0x77, adr=3 in the same cycle -> write dropped, busy next cycle, later read 3 = 0x00.
- Out of range: DEPTH=3, ADDR_W=2; write 0x55@3, then read 3 -> out=0x00, out_valid=1; mem[0..2] unchanged.
- Reset mid-read and parity (macro defined): issue read, assert rst on the next edge -> out_valid=0, out=0, busy=1. After the clear, write 0x0F@0, force-flip the stored data bit 0, read 0 -> par_err=1 with out_valid=1.

Source files
------------

// File: rtl/param_byte_memory.sv
// param_byte_memory: DEPTH x DATA_W single-port store with registered read, hardware zero-fill and busy flag.
// Optional PARAM_BYTE_MEMORY_PARITY_EN adds a per-word even-parity bit and a par_err output.
module param_byte_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
`ifdef PARAM_BYTE_MEMORY_PARITY_EN
  output logic              par_err,
`endif
  output logic              busy
);
`ifdef PARAM_BYTE_MEMORY_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [MW-1:0]     mem [DEPTH];
  logic [MW-1:0]     wdat;
  logic              ok;
  logic              last;
`ifdef PARAM_BYTE_MEMORY_PARITY_EN
  assign wdat = {^data, data};
`else
  assign wdat = data;
`endif
  assign ok   = 32'(adr) < DEPTH;
  assign last = cnt == ADDR_W'(DEPTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      busy      <= 1'b1;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef PARAM_BYTE_MEMORY_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else if (state == CLEAR) begin
      mem[cnt]  <= '0;
      out_valid <= 1'b0;
      cnt       <= last ? '0 : cnt + 1'b1;
      if (last) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else if (clr) begin
      state     <= CLEAR;
      cnt       <= '0;
      busy      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en && !wr;
      if (en && wr && ok) mem[adr] <= wdat;
      if (en && !wr) begin
        out <= ok ? mem[adr][DATA_W-1:0] : '0;
`ifdef PARAM_BYTE_MEMORY_PARITY_EN
        par_err <= ok ? ^mem[adr] : 1'b0;
`endif
      end
    end
  end
endmodule
